// File: rtl/alu_issue.sv
// alu_issue: issue/collect controller for the multi-cycle CPU ALU.
// Accepts one op at a time, pulses ALU_en with held operands, waits for
// ALU_vld (bounded by TIMEOUT), then offers the result downstream.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no op outstanding; ready for a new op
// ISSUE | ALU_en pulse with operands held; wait counter cleared
// WAIT  | waiting for ALU_vld or timeout
// DONE  | result presented on res/res_vld until res_rdy

module alu_issue #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op_A,
  input  logic [31:0] op_B,
  input  logic [3:0]  op_sel,
  input  logic        op_vld,
  output logic        op_rdy,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALU_sel,
  output logic        ALU_en,
  input  logic [31:0] ALU_out,
  input  logic        set,
  input  logic        eq,
  input  logic        gt,
  input  logic        ge,
  input  logic        ALU_vld,
  output logic        ALU_ack,
  output logic [31:0] res,
  output logic [3:0]  res_flags,
  output logic        res_err,
  output logic        res_vld,
  input  logic        res_rdy,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter only has to reach TIMEOUT-1; keep at least one bit so a
  // disabled timeout still elaborates cleanly.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [31:0]   ERR_RES  = 32'h2BADDEAD;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   res_q, res_d;
  logic [3:0]    flags_q, flags_d;
  logic          err_q, err_d;
  logic          accept;

  // Upstream ready, issue pulse, stale-result drain and status flags.
  always_comb begin
    op_rdy  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && res_rdy));
    accept  = op_vld && op_rdy;
    ALU_en  = (state_q == S_ISSUE);
    ALU_ack = !rst && ALU_vld && (state_q != S_ISSUE);
    res_vld = (state_q == S_DONE);
    busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  end

  // Next-state and datapath capture; every register holds unless updated.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = op_A;
          b_d     = op_B;
          sel_d   = op_sel;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (ALU_vld) begin
          res_d   = ALU_out;
          flags_d = {set, ge, gt, eq};
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          res_d   = ERR_RES;
          flags_d = 4'b0000;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_rdy) begin
          if (accept) begin
            a_d     = op_A;
            b_d     = op_B;
            sel_d   = op_sel;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_sel   = sel_q;
  assign res       = res_q;
  assign res_flags = flags_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural ALU model.
module tb_alu_issue;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_A, op_B;
  logic [3:0]  op_sel;
  logic        op_vld, op_rdy;
  logic [31:0] A, B;
  logic [3:0]  ALU_sel;
  logic        ALU_en;
  logic [31:0] ALU_out;
  logic        set, eq, gt, ge;
  logic        ALU_vld, ALU_ack;
  logic [31:0] res;
  logic [3:0]  res_flags;
  logic        res_err, res_vld, res_rdy, busy;

  alu_issue #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op_A(op_A), .op_B(op_B), .op_sel(op_sel),
    .op_vld(op_vld), .op_rdy(op_rdy), .A(A), .B(B), .ALU_sel(ALU_sel),
    .ALU_en(ALU_en), .ALU_out(ALU_out), .set(set), .eq(eq), .gt(gt), .ge(ge),
    .ALU_vld(ALU_vld), .ALU_ack(ALU_ack), .res(res), .res_flags(res_flags),
    .res_err(res_err), .res_vld(res_vld), .res_rdy(res_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
    logic [31:0] r;
    case (sel)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~(a | b);
      4'd6:    r = a << b[4:0];
      4'd7:    r = a >> b[4:0];
      4'd8:    r = a * b;
      4'd9:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd10:   r = (b == 0) ? a : a % b;
      default: r = 32'h2BADDEAD;
    endcase
    return {r, (a <= b), (a >= b), (a > b), (a == b)};
  endfunction

  // cycles from ALU_en to ALU_vld for a healthy ALU
  function automatic int nat_delay(input logic [3:0] sel);
    if (sel < 4'd8) return 1;
    if (sel == 4'd8) return 6;
    return 33;
  endfunction

  // ---------------- ALU model ----------------
  int          alu_ovr = -1;   // -1 natural latency, 0 withhold ALU_vld, >0 forced latency
  logic        inj = 1'b0;     // stray ALU_vld pulse
  logic        pend;
  int          tmr;
  int          alu_d;
  logic [31:0] alu_res_r;
  logic [3:0]  alu_flg_r;

  always_comb alu_d = (alu_ovr >= 0) ? alu_ovr : nat_delay(ALU_sel);

  assign ALU_out = alu_res_r;
  assign {set, ge, gt, eq} = alu_flg_r;
  assign ALU_vld = (pend && (tmr == 0)) || inj;

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      tmr <= 0;
      alu_res_r <= '0;
      alu_flg_r <= '0;
    end else if (ALU_en) begin
      {alu_res_r, alu_flg_r} <= ref_alu(A, B, ALU_sel);
      pend <= (alu_d > 0);
      tmr <= alu_d - 1;
    end else if (pend) begin
      if (tmr != 0) tmr <= tmr - 1;
      else if (ALU_ack) pend <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
    int          t_vld;
  } exp_t;

  exp_t sb[$];
  int   en_q[$];
  logic prev_vld = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vld = 1'b0;
        continue;
      end
      if (ALU_en) begin
        if (en_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL alu_en_unexpected: got ALU_en=1 with no pending issue, required 0 (cycle %0d)", cyc);
        end else begin
          chk("alu_en_cycle", 64'(cyc), 64'(en_q.pop_front()));
        end
      end
      if (res_vld) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL res_vld_unexpected: got res_vld=1 res=%h with nothing outstanding, required 0 (cycle %0d)", res, cyc);
        end else begin
          if (!prev_vld) chk("res_vld_cycle", 64'(cyc), 64'(sb[0].t_vld));
          chk("result", 64'({res, res_flags, res_err}),
              64'({sb[0].res, sb[0].flags, sb[0].err}));
          if (res_rdy) void'(sb.pop_front());
        end
      end
      prev_vld = res_vld;
    end
  end

  // ---------------- downstream ready ----------------
  int rdy_mode = 1;   // 0 low, 1 high, 2 random
  initial begin
    res_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       res_rdy = 1'b0;
        1:       res_rdy = 1'b1;
        default: res_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_op_x(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                           input logic [31:0] eres, input logic [3:0] eflg, input logic eerr,
                           input int lat, output int t_acc);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    op_A = a; op_B = b; op_sel = sel; op_vld = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (op_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    t_acc = cyc;
    if (ok) begin
      e.res = eres; e.flags = eflg; e.err = eerr; e.t_vld = cyc + lat;
      sb.push_back(e);
      en_q.push_back(cyc + 1);
    end else begin
      n_chk++; n_fail++;
      $display("FAIL op_accept_timeout: op_rdy stayed 0, required 1 (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    op_vld = 1'b0;
  endtask

  // expectation derived from the ALU's latency rule and the timeout rule
  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    int d, t;
    logic [35:0] r;
    d = (alu_ovr >= 0) ? alu_ovr : nat_delay(sel);
    if (d == 0 || d > TO) begin
      send_op_x(a, b, sel, 32'h2BADDEAD, 4'b0000, 1'b1, TO + 2, t);
    end else begin
      r = ref_alu(a, b, sel);
      send_op_x(a, b, sel, r[35:4], r[3:0], 1'b0, d + 2, t);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #3;
      if (sb.size() == 0 && en_q.size() == 0 && !busy && !res_vld) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d results still outstanding, required 0", sb.size());
      sb.delete();
      en_q.delete();
    end
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t1, t2, t;
    logic [31:0] a, b;
    logic [3:0]  s;
    bit seen;

    rst = 1'b1; op_vld = 1'b0; op_A = '0; op_B = '0; op_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("op_rdy_in_reset", 64'(op_rdy), 64'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("reset_op_rdy", 64'(op_rdy), 64'(1));
    chk("reset_ctrl", 64'({ALU_en, ALU_ack, res_vld, busy, res_err}), 64'(0));
    chk("reset_res", 64'({res, res_flags}), 64'(0));
    chk("reset_A", 64'(A), 64'(0));
    chk("reset_B_sel", 64'({B, ALU_sel}), 64'(0));
    @(posedge clk); #1;

    // ADD, MUL, DIV, MOD with known answers
    rdy_mode = 1;
    send_op_x(32'd5, 32'd3, 4'd0, 32'd8, 4'b0110, 1'b0, 3, t);
    wait_idle();
    send_op_x(32'd7, 32'd6, 4'd8, 32'd42, 4'b0110, 1'b0, 8, t);
    wait_idle();
    send_op_x(32'd100, 32'd7, 4'd9, 32'd14, 4'b0110, 1'b0, 35, t);
    wait_idle();
    send_op_x(32'd100, 32'd7, 4'd10, 32'd2, 4'b0110, 1'b0, 35, t);
    wait_idle();

    // back-to-back single-cycle ops: one accept every 3 cycles
    send_op_x(32'd1, 32'd2, 4'd0, 32'd3, 4'b1000, 1'b0, 3, t1);
    send_op_x(32'hF0, 32'h0F, 4'd3, 32'hFF, 4'b0110, 1'b0, 3, t2);
    chk("b2b_spacing", 64'(t2 - t1), 64'(3));
    wait_idle();

    // backpressure: result held, no new accept, no issue
    rdy_mode = 0;
    send_op_x(32'd10, 32'd20, 4'd0, 32'd30, 4'b1000, 1'b0, 3, t);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_vld) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_res_vld_seen", 64'(seen), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({res, res_vld, op_rdy, ALU_en}), 64'({32'd30, 1'b1, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    send_op_x(32'd9, 32'd4, 4'd1, 32'd5, 4'b0110, 1'b0, 3, t);
    wait_idle();

    // timeout with ALU_vld withheld, then a late stray ALU_vld
    alu_ovr = 0;
    send_op_x(32'd1, 32'd1, 4'd0, 32'h2BADDEAD, 4'b0000, 1'b1, TO + 2, t);
    wait_idle();
    alu_ovr = -1;
    @(posedge clk); #1; inj = 1'b1;
    @(negedge clk);
    chk("late_vld_ack", 64'(ALU_ack), 64'(1));
    @(posedge clk); #1; inj = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("late_vld_no_result", 64'({res_vld, busy}), 64'(0));
    @(posedge clk); #1;

    // ALU_vld on the last counted WAIT cycle wins; one cycle later is a timeout
    alu_ovr = TO;
    send_op(32'd4, 32'd5, 4'd2);
    wait_idle();
    alu_ovr = TO + 1;
    send_op(32'd4, 32'd5, 4'd3);
    wait_idle();
    alu_ovr = -1;

    // reset in the middle of a DIV
    send_op_x(32'd100, 32'd7, 4'd9, 32'd14, 4'b0110, 1'b0, 35, t);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    sb.delete();
    en_q.delete();
    @(negedge clk);
    chk("rst_mid_op", 64'({busy, res_vld, op_rdy}), 64'(3'b001));
    repeat (40) @(posedge clk);
    #1;
    send_op_x(32'd9, 32'd4, 4'd1, 32'd5, 4'b0110, 1'b0, 3, t);
    wait_idle();

    // unsupported op code and equal-operand compare
    send_op_x(32'd1, 32'd2, 4'd12, 32'h2BADDEAD, 4'b1000, 1'b0, 35, t);
    wait_idle();
    send_op_x(32'd3, 32'd3, 4'd0, 32'd6, 4'b1101, 1'b0, 3, t);
    wait_idle();

    // randomized traffic with random backpressure
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) != 0) s = 4'($urandom_range(0, 7));
      else                           s = 4'($urandom_range(8, 15));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send_op(a, b, s);
    end
    rdy_mode = 1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
